// File: rtl/alu_share_arb_if.sv
// Request/response handshake bundle between the two requesters and alu_share_arb.
// slave = arbiter side, master = requester side.
interface alu_share_arb_if #(
  parameter int W  = 8,
  parameter int CW = 4
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [CW-1:0] req_cmd0;
  logic [CW-1:0] req_cmd1;
  logic [W-1:0]  req_a0;
  logic [W-1:0]  req_a1;
  logic [W-1:0]  req_b0;
  logic [W-1:0]  req_b1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [W-1:0]  rsp_rslt;
  logic          rsp_beq;
  logic          rsp_slt;

  modport slave (
    input  req_valid, req_cmd0, req_cmd1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_rslt, rsp_beq, rsp_slt
  );

  modport master (
    output req_valid, req_cmd0, req_cmd1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_rslt, rsp_beq, rsp_slt
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU between two requesters, one op in flight.
// Optional counters grant_cnt0/grant_cnt1/stall_cnt enabled by ALU_SHARE_ARB_PERF_EN.
module alu_share_arb #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_share_arb_if.slave arb_bus,
  output logic [CW-1:0] alu_cmd,
  output logic [W-1:0]  alu_inA,
  output logic [W-1:0]  alu_inB,
  input  logic [W-1:0]  alu_rslt,
  input  logic          alu_beq,
  input  logic          alu_slt
`ifdef ALU_SHARE_ARB_PERF_EN
  ,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_rr_ptr;
  logic [CW-1:0] r_op_cmd;
  logic [W-1:0]  r_op_a;
  logic [W-1:0]  r_op_b;
  logic [W-1:0]  r_rsp_rslt;
  logic          r_rsp_beq;
  logic          r_rsp_slt;

  logic          w_any_req;
  logic          w_grant;
  logic [1:0]    w_req_ready;
  logic          w_req_hs;
  logic [1:0]    w_rsp_valid;
  logic          w_rsp_hs;
  logic [CW-1:0] w_sel_cmd;
  logic [W-1:0]  w_sel_a;
  logic [W-1:0]  w_sel_b;

  // Lone requester wins outright; on contention rr_ptr decides.
  always_comb begin
    w_any_req = |arb_bus.req_valid;
    w_grant   = arb_bus.req_valid[1] & (~arb_bus.req_valid[0] | r_rr_ptr);
    w_sel_cmd = w_grant ? arb_bus.req_cmd1 : arb_bus.req_cmd0;
    w_sel_a   = w_grant ? arb_bus.req_a1   : arb_bus.req_a0;
    w_sel_b   = w_grant ? arb_bus.req_b1   : arb_bus.req_b0;
  end

  // Handshake outputs are gated by reset so nothing can complete on a reset edge.
  always_comb begin
    w_req_ready = 2'b00;
    if (!reset && (r_state == ST_IDLE) && w_any_req)
      w_req_ready = w_grant ? 2'b10 : 2'b01;
    w_rsp_valid = 2'b00;
    if (!reset && (r_state == ST_RESP))
      w_rsp_valid = r_owner ? 2'b10 : 2'b01;
    w_req_hs = |(arb_bus.req_valid & w_req_ready);
    w_rsp_hs = |(w_rsp_valid & arb_bus.rsp_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_op_cmd   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_rsp_rslt <= '0;
      r_rsp_beq  <= 1'b0;
      r_rsp_slt  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_hs) begin
            r_op_cmd <= w_sel_cmd;
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_owner  <= w_grant;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_rslt <= alu_rslt;
          r_rsp_beq  <= alu_beq;
          r_rsp_slt  <= alu_slt;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rr_ptr <= ~r_owner;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign arb_bus.req_ready = w_req_ready;
  assign arb_bus.rsp_valid = w_rsp_valid;
  assign arb_bus.rsp_rslt  = r_rsp_rslt;
  assign arb_bus.rsp_beq   = r_rsp_beq;
  assign arb_bus.rsp_slt   = r_rsp_slt;
  assign alu_cmd           = r_op_cmd;
  assign alu_inA           = r_op_a;
  assign alu_inB           = r_op_b;

`ifdef ALU_SHARE_ARB_PERF_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_req_hs && !w_grant && (r_grant_cnt0 != '1))
        r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_req_hs && w_grant && (r_grant_cnt1 != '1))
        r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
      if (w_any_req && (w_req_ready == 2'b00) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule
